int_responder: RTL and testbench

INT_RESPONDER -- requirements
Module: int_responder

---
 rtl/int_responder.sv | 118 +++++++++++
 tb/tb_int_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/int_responder.sv
// Interrupt entry sequencer: takes an FIQ/IRQ at an instruction boundary and
// issues the acknowledge, SPSR/LR banking, CPSR update and vector load.
module int_responder #(
  parameter logic [31:0] IRQ_VEC = 32'h0000_0018,
  parameter logic [31:0] FIQ_VEC = 32'h0000_001C
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        INT_irq,
  input  logic        INT_fiq,
  input  logic        Insn_done,
  input  logic [31:0] CPSR_in,
  input  logic [31:0] PC_in,
  output logic        INTA_irq,
  output logic        INTA_fiq,
  output logic        SPSR_we,
  output logic [31:0] SPSR_out,
  output logic        LR_we,
  output logic [31:0] LR_out,
  output logic        CPSR_we,
  output logic [31:0] CPSR_out,
  output logic        PC_we,
  output logic [31:0] PC_out,
  output logic        Busy
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    VECT = 2'd2
  } state_t;

  state_t       state;
  logic         fiq_q;
  logic [W-1:0] cpsr_q;

  logic take_fiq_c;
  logic take_irq_c;

  // FIQ beats IRQ when both are takeable; the IRQ simply stays pending
  assign take_fiq_c = Insn_done && INT_fiq && !CPSR_in[6];
  assign take_irq_c = Insn_done && INT_irq && !CPSR_in[7];

  // Mode switch, masks set and Thumb cleared on entry
  function automatic logic [W-1:0] entry_cpsr(input logic [W-1:0] c, input logic fiq);
    logic [W-1:0] r;
    r      = c;
    r[4:0] = fiq ? 5'b10001 : 5'b10010;
    r[5]   = 1'b0;
    r[7]   = 1'b1;
    if (fiq) r[6] = 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state    <= IDLE;
      fiq_q    <= 1'b0;
      cpsr_q   <= '0;
      INTA_irq <= 1'b0;
      INTA_fiq <= 1'b0;
      SPSR_we  <= 1'b0;
      SPSR_out <= '0;
      LR_we    <= 1'b0;
      LR_out   <= '0;
      CPSR_we  <= 1'b0;
      CPSR_out <= '0;
      PC_we    <= 1'b0;
      PC_out   <= '0;
      Busy     <= 1'b0;
    end else begin
      INTA_irq <= 1'b0;
      INTA_fiq <= 1'b0;
      SPSR_we  <= 1'b0;
      SPSR_out <= '0;
      LR_we    <= 1'b0;
      LR_out   <= '0;
      CPSR_we  <= 1'b0;
      CPSR_out <= '0;
      PC_we    <= 1'b0;
      PC_out   <= '0;
      Busy     <= 1'b0;
      case (state)
        IDLE: begin
          if (take_fiq_c || take_irq_c) begin
            state    <= ACK;
            fiq_q    <= take_fiq_c;
            cpsr_q   <= CPSR_in;
            INTA_fiq <= take_fiq_c;
            INTA_irq <= !take_fiq_c;
            SPSR_we  <= 1'b1;
            SPSR_out <= CPSR_in;
            LR_we    <= 1'b1;
            LR_out   <= W'(PC_in + W'(4));
            Busy     <= 1'b1;
          end
        end
        ACK: begin
          state    <= VECT;
          CPSR_we  <= 1'b1;
          CPSR_out <= entry_cpsr(cpsr_q, fiq_q);
          PC_we    <= 1'b1;
          PC_out   <= fiq_q ? FIQ_VEC : IRQ_VEC;
          Busy     <= 1'b1;
        end
        VECT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_responder.sv
// Directed bench for int_responder: entry sequences, priority, masking,
// LR wrap-around and reset abort, checked with immediate assertions.
module tb_int_responder;

  logic        clk;
  logic        Rst;
  logic        INT_irq;
  logic        INT_fiq;
  logic        Insn_done;
  logic [31:0] CPSR_in;
  logic [31:0] PC_in;
  logic        INTA_irq;
  logic        INTA_fiq;
  logic        SPSR_we;
  logic [31:0] SPSR_out;
  logic        LR_we;
  logic [31:0] LR_out;
  logic        CPSR_we;
  logic [31:0] CPSR_out;
  logic        PC_we;
  logic [31:0] PC_out;
  logic        Busy;

  int n_checks = 0;
  int n_fails  = 0;

  int_responder dut (
    .clk      (clk),
    .Rst      (Rst),
    .INT_irq  (INT_irq),
    .INT_fiq  (INT_fiq),
    .Insn_done(Insn_done),
    .CPSR_in  (CPSR_in),
    .PC_in    (PC_in),
    .INTA_irq (INTA_irq),
    .INTA_fiq (INTA_fiq),
    .SPSR_we  (SPSR_we),
    .SPSR_out (SPSR_out),
    .LR_we    (LR_we),
    .LR_out   (LR_out),
    .CPSR_we  (CPSR_we),
    .CPSR_out (CPSR_out),
    .PC_we    (PC_we),
    .PC_out   (PC_out),
    .Busy     (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs observed 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {INTA_irq, INTA_fiq, SPSR_we, LR_we, CPSR_we, PC_we, Busy}
  task automatic chk_strobes(input string tag, input logic [6:0] exp);
    chk(tag, 32'({INTA_irq, INTA_fiq, SPSR_we, LR_we, CPSR_we, PC_we, Busy}), 32'(exp));
  endtask

  initial begin
    Rst = 1'b0; INT_irq = 1'b0; INT_fiq = 1'b0; Insn_done = 1'b0;
    CPSR_in = '0; PC_in = '0;

    // Reset state
    tick(); tick();
    chk_strobes("reset_strobes", 7'b0000000);
    chk("reset_spsr", SPSR_out, 32'h0);
    chk("reset_lr",   LR_out,   32'h0);
    chk("reset_cpsr", CPSR_out, 32'h0);
    chk("reset_pc",   PC_out,   32'h0);
    Rst = 1'b1;
    tick();
    chk_strobes("idle_after_reset", 7'b0000000);

    // Basic IRQ entry; inputs disturbed after the take must not matter
    CPSR_in = 32'h0000_0013; PC_in = 32'h0000_1000; INT_irq = 1'b1; Insn_done = 1'b1;
    tick();
    chk_strobes("irq_ack_strobes", 7'b1011001);
    chk("irq_ack_spsr", SPSR_out, 32'h0000_0013);
    chk("irq_ack_lr",   LR_out,   32'h0000_1004);
    INT_irq = 1'b0; CPSR_in = 32'hFFFF_FFFF; PC_in = 32'h0; Insn_done = 1'b1;
    tick();
    chk_strobes("irq_vect_strobes", 7'b0000111);
    chk("irq_vect_cpsr", CPSR_out, 32'h0000_0092);
    chk("irq_vect_pc",   PC_out,   32'h0000_0018);
    Insn_done = 1'b0;
    tick();
    chk_strobes("irq_back_idle", 7'b0000000);

    // Masked IRQ stays idle; unmasked FIQ then taken
    CPSR_in = 32'h0000_0093; PC_in = 32'h0000_2000; INT_irq = 1'b1; INT_fiq = 1'b0; Insn_done = 1'b1;
    tick();
    chk_strobes("masked_irq_1", 7'b0000000);
    tick();
    chk_strobes("masked_irq_2", 7'b0000000);
    INT_fiq = 1'b1;
    tick();
    chk_strobes("mask_fiq_ack", 7'b0111001);
    chk("mask_fiq_spsr", SPSR_out, 32'h0000_0093);
    chk("mask_fiq_lr",   LR_out,   32'h0000_2004);
    Insn_done = 1'b0;
    tick();
    chk_strobes("mask_fiq_vect", 7'b0000111);
    chk("mask_fiq_cpsr", CPSR_out, 32'h0000_00D1);
    chk("mask_fiq_pc",   PC_out,   32'h0000_001C);
    tick();
    chk_strobes("mask_fiq_idle", 7'b0000000);

    // Request without an instruction boundary is not taken
    INT_fiq = 1'b0; INT_irq = 1'b1; CPSR_in = 32'h0000_0013; Insn_done = 1'b0;
    tick();
    chk_strobes("no_insn_done", 7'b0000000);

    // Simultaneous requests: FIQ wins, LR wraps, IRQ taken afterwards
    INT_irq = 1'b1; INT_fiq = 1'b1; CPSR_in = 32'h0000_0013; PC_in = 32'hFFFF_FFFC; Insn_done = 1'b1;
    tick();
    chk_strobes("sim_fiq_ack", 7'b0111001);
    chk("sim_fiq_spsr", SPSR_out, 32'h0000_0013);
    chk("wrap_lr",      LR_out,   32'h0000_0000);
    Insn_done = 1'b0;
    tick();
    chk_strobes("sim_fiq_vect", 7'b0000111);
    chk("sim_fiq_cpsr", CPSR_out, 32'h0000_00D1);
    chk("sim_fiq_pc",   PC_out,   32'h0000_001C);
    tick();
    chk_strobes("sim_idle", 7'b0000000);
    INT_fiq = 1'b0; PC_in = 32'h0000_3000; Insn_done = 1'b1;
    tick();
    chk_strobes("pending_irq_ack", 7'b1011001);
    chk("pending_irq_lr", LR_out, 32'h0000_3004);
    Insn_done = 1'b0;
    tick();
    chk("pending_irq_cpsr", CPSR_out, 32'h0000_0092);
    tick();

    // FIQ arriving during an IRQ entry is taken at the next boundary
    INT_irq = 1'b1; INT_fiq = 1'b0; CPSR_in = 32'h0000_0013; PC_in = 32'h0000_4000; Insn_done = 1'b1;
    tick();
    chk_strobes("late_irq_ack", 7'b1011001);
    INT_fiq = 1'b1; Insn_done = 1'b0;
    tick();
    chk("late_irq_pc", PC_out, 32'h0000_0018);
    tick();
    chk_strobes("late_idle", 7'b0000000);
    Insn_done = 1'b1;
    tick();
    chk_strobes("late_fiq_ack", 7'b0111001);
    Insn_done = 1'b0; INT_fiq = 1'b0; INT_irq = 1'b0;
    tick();
    chk("late_fiq_pc", PC_out, 32'h0000_001C);
    tick();

    // Reset at the ACK edge aborts the entry
    INT_irq = 1'b1; CPSR_in = 32'h0000_0013; PC_in = 32'h0000_5000; Insn_done = 1'b1;
    tick();
    chk_strobes("rst_pre_ack", 7'b1011001);
    Rst = 1'b0; Insn_done = 1'b0;
    tick();
    chk_strobes("rst_abort_strobes", 7'b0000000);
    chk("rst_abort_spsr", SPSR_out, 32'h0);
    chk("rst_abort_lr",   LR_out,   32'h0);
    chk("rst_abort_cpsr", CPSR_out, 32'h0);
    chk("rst_abort_pc",   PC_out,   32'h0);
    Rst = 1'b1; INT_irq = 1'b0;
    tick();
    chk_strobes("rst_after_1", 7'b0000000);
    tick();
    chk_strobes("rst_after_2", 7'b0000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
